fft_third_stage: RTL

//  Final radix-2 stage of the 8-point FFT; sits directly after fft_SecondStage.

---
 rtl/fft_third_stage.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_third_stage.sv
// Last radix-2 stage of the 8-point FFT: twiddles the odd 4-point DFT, runs the
// butterflies with a rounded 1/2 scale and streams X0..X7 over valid/ready.
module fft_third_stage #(
    parameter int WIDTH     = 16,
    parameter int COEF_FRAC = 14,
    parameter int COEF      = 11585
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in_0_real,
    input  logic [WIDTH-1:0] x_in_0_imag,
    input  logic [WIDTH-1:0] x_in_1_real,
    input  logic [WIDTH-1:0] x_in_1_imag,
    input  logic [WIDTH-1:0] x_in_2_real,
    input  logic [WIDTH-1:0] x_in_2_imag,
    input  logic [WIDTH-1:0] x_in_3_real,
    input  logic [WIDTH-1:0] x_in_3_imag,
    input  logic [WIDTH-1:0] x_in_4_real,
    input  logic [WIDTH-1:0] x_in_4_imag,
    input  logic [WIDTH-1:0] x_in_5_real,
    input  logic [WIDTH-1:0] x_in_5_imag,
    input  logic [WIDTH-1:0] x_in_6_real,
    input  logic [WIDTH-1:0] x_in_6_imag,
    input  logic [WIDTH-1:0] x_in_7_real,
    input  logic [WIDTH-1:0] x_in_7_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             out_sat
);
    localparam int PW = WIDTH + COEF_FRAC + 3;
    localparam logic signed [PW-1:0]      COEF_S = PW'(COEF);
    localparam logic signed [PW-1:0]      BIAS   = PW'(2 ** (COEF_FRAC - 1));
    localparam logic signed [WIDTH+1:0]   ONE    = (WIDTH+2)'(1);
    localparam logic signed [WIDTH+1:0]   MAXV   = (WIDTH+2)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [WIDTH+1:0]   MINV   = -(WIDTH+2)'(2 ** (WIDTH - 1));

    typedef enum logic [1:0] {IDLE, MUL, BFLY, OUT} state_t;
    state_t state_q, state_d;

    logic [WIDTH-1:0]        x_re [8];
    logic [WIDTH-1:0]        x_im [8];
    logic [WIDTH-1:0]        cap_re_q [8], cap_re_d [8];
    logic [WIDTH-1:0]        cap_im_q [8], cap_im_d [8];
    logic signed [WIDTH:0]   t_re_q [4], t_re_d [4];
    logic signed [WIDTH:0]   t_im_q [4], t_im_d [4];
    logic [WIDTH-1:0]        bin_re_q [8], bin_re_d [8];
    logic [WIDTH-1:0]        bin_im_q [8], bin_im_d [8];
    logic                    sat_q [8], sat_d [8];
    logic [2:0]              idx_q, idx_d;
    logic signed [WIDTH:0]   tw_re [4];
    logic signed [WIDTH:0]   tw_im [4];
    logic [WIDTH-1:0]        bf_re [8];
    logic [WIDTH-1:0]        bf_im [8];
    logic                    bf_sat [8];

    assign x_re = '{x_in_0_real, x_in_1_real, x_in_2_real, x_in_3_real,
                    x_in_4_real, x_in_5_real, x_in_6_real, x_in_7_real};
    assign x_im = '{x_in_0_imag, x_in_1_imag, x_in_2_imag, x_in_3_imag,
                    x_in_4_imag, x_in_5_imag, x_in_6_imag, x_in_7_imag};

    // s * (1/sqrt2), rounded half-up in the fixed-point domain
    function automatic logic signed [WIDTH:0] rnd(input logic signed [WIDTH:0] s);
        logic signed [PW-1:0] p;
        p = {{(PW-WIDTH-1){s[WIDTH]}}, s};
        p = (p * COEF_S + BIAS) >>> COEF_FRAC;
        return p[WIDTH:0];
    endfunction

    // Returns {saturated, value} for the rounded half of a butterfly sum
    function automatic logic [WIDTH:0] sat_half(input logic signed [WIDTH+1:0] u);
        logic signed [WIDTH+1:0] v;
        v = (u + ONE) >>> 1;
        if (v > MAXV)
            return {1'b1, MAXV[WIDTH-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[WIDTH-1:0]};
        else
            return {1'b0, v[WIDTH-1:0]};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_k
            logic signed [WIDTH:0]   a_re, a_im, b_re, b_im, sum_bb, dif_bb;
            logic signed [WIDTH+1:0] up_re, up_im, um_re, um_im;
            logic [WIDTH:0]          sp_re, sp_im, sm_re, sm_im;

            assign a_re   = {cap_re_q[gi][WIDTH-1], cap_re_q[gi]};
            assign a_im   = {cap_im_q[gi][WIDTH-1], cap_im_q[gi]};
            assign b_re   = {cap_re_q[gi+4][WIDTH-1], cap_re_q[gi+4]};
            assign b_im   = {cap_im_q[gi+4][WIDTH-1], cap_im_q[gi+4]};
            assign sum_bb = b_re + b_im;
            assign dif_bb = b_im - b_re;

            if (gi == 0) begin : g_w0
                assign tw_re[gi] = b_re;
                assign tw_im[gi] = b_im;
            end else if (gi == 1) begin : g_w1
                assign tw_re[gi] = rnd(sum_bb);
                assign tw_im[gi] = rnd(dif_bb);
            end else if (gi == 2) begin : g_w2
                assign tw_re[gi] = b_im;
                assign tw_im[gi] = -b_re;
            end else begin : g_w3
                assign tw_re[gi] = rnd(dif_bb);
                assign tw_im[gi] = -rnd(sum_bb);
            end

            assign up_re = {a_re[WIDTH], a_re} + {t_re_q[gi][WIDTH], t_re_q[gi]};
            assign up_im = {a_im[WIDTH], a_im} + {t_im_q[gi][WIDTH], t_im_q[gi]};
            assign um_re = {a_re[WIDTH], a_re} - {t_re_q[gi][WIDTH], t_re_q[gi]};
            assign um_im = {a_im[WIDTH], a_im} - {t_im_q[gi][WIDTH], t_im_q[gi]};
            assign sp_re = sat_half(up_re);
            assign sp_im = sat_half(up_im);
            assign sm_re = sat_half(um_re);
            assign sm_im = sat_half(um_im);

            assign bf_re[gi]    = sp_re[WIDTH-1:0];
            assign bf_im[gi]    = sp_im[WIDTH-1:0];
            assign bf_sat[gi]   = sp_re[WIDTH] | sp_im[WIDTH];
            assign bf_re[gi+4]  = sm_re[WIDTH-1:0];
            assign bf_im[gi+4]  = sm_im[WIDTH-1:0];
            assign bf_sat[gi+4] = sm_re[WIDTH] | sm_im[WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     state_d = BFLY;
            BFLY:    state_d = OUT;
            OUT:     if (out_ready && idx_q == 3'd7) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        out_last  = (state_q == OUT) && (idx_q == 3'd7);
    end

    always_comb begin
        cap_re_d = cap_re_q;
        cap_im_d = cap_im_q;
        t_re_d   = t_re_q;
        t_im_d   = t_im_q;
        bin_re_d = bin_re_q;
        bin_im_d = bin_im_q;
        sat_d    = sat_q;
        idx_d    = idx_q;
        if (state_q == IDLE && in_valid) begin
            cap_re_d = x_re;
            cap_im_d = x_im;
        end
        if (state_q == MUL) begin
            t_re_d = tw_re;
            t_im_d = tw_im;
        end
        if (state_q == BFLY) begin
            bin_re_d = bf_re;
            bin_im_d = bf_im;
            sat_d    = bf_sat;
        end
        // Index wraps 7 -> 0, so the next frame starts at bin 0
        if (state_q == OUT && out_ready)
            idx_d = idx_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cap_re_q[i] <= '0;
                cap_im_q[i] <= '0;
                bin_re_q[i] <= '0;
                bin_im_q[i] <= '0;
                sat_q[i]    <= 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                t_re_q[i] <= '0;
                t_im_q[i] <= '0;
            end
            idx_q <= 3'd0;
        end else begin
            cap_re_q <= cap_re_d;
            cap_im_q <= cap_im_d;
            t_re_q   <= t_re_d;
            t_im_q   <= t_im_d;
            bin_re_q <= bin_re_d;
            bin_im_q <= bin_im_d;
            sat_q    <= sat_d;
            idx_q    <= idx_d;
        end
    end

    assign out_real  = bin_re_q[idx_q];
    assign out_imag  = bin_im_q[idx_q];
    assign out_sat   = sat_q[idx_q];
    assign out_index = idx_q;
endmodule
